// File: rtl/icache_axi_rd.sv
`timescale 1ns/1ps
// icache_axi_rd: turns an icache line-fill request into one AXI4 INCR read burst
// and forwards each returned beat; protocol anomalies latch a sticky error.
module icache_axi_rd #(
  parameter logic [3:0]  AXI_ID = 4'd0,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ram_raddr_i,
  input  logic              ram_raddr_valid_i,
  input  logic [7:0]        ram_rmask_i,
  input  logic [3:0]        ram_rsize_i,
  input  logic [7:0]        ram_rlen_i,
  output logic              ram_rdata_ready_o,
  output logic [DATA_W-1:0] ram_rdata_o,
  output logic              arvalid,
  input  logic              arready,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [3:0]        arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [3:0]        rid,
  output logic              err_o
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [2:0]  r_arsize;
  logic        r_err;

  logic [2:0]  w_arsize_map;
  logic        w_size_bad;
  logic        w_accept;
  logic        w_beat;
  logic        w_len_err;
  logic        w_err_set;
  logic        w_unused_rmask;

  // AXI reads are always full-width, so the byte mask has no consumer.
  assign w_unused_rmask = ^ram_rmask_i;

  assign w_accept = (r_state == S_IDLE) && ram_raddr_valid_i;
  assign w_beat   = (r_state == S_R) && rvalid;

  always_comb begin
    w_arsize_map = 3'd3;
    w_size_bad   = 1'b0;
    case (ram_rsize_i)
      4'd1:    w_arsize_map = 3'd0;
      4'd2:    w_arsize_map = 3'd1;
      4'd4:    w_arsize_map = 3'd2;
      4'd8:    w_arsize_map = 3'd3;
      default: w_size_bad   = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ram_raddr_valid_i) w_next = S_AR;
      S_AR:    if (arready) w_next = S_R;
      S_R:     if (rvalid && rlast) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Length mismatch is only flagged; the burst still ends on rlast alone.
  assign w_len_err = rlast ? (r_cnt != r_len) : (r_cnt == r_len);
  assign w_err_set = (w_accept && w_size_bad) ||
                     (w_beat && (w_len_err || (rresp != 2'b00) || (rid != AXI_ID)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_arsize <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= ram_raddr_i;
        r_len    <= ram_rlen_i;
        r_arsize <= w_arsize_map;
        r_cnt    <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign arvalid           = (r_state == S_AR);
  assign rready            = (r_state == S_R);
  assign araddr            = r_addr;
  assign arlen             = r_len;
  assign arsize            = r_arsize;
  assign arburst           = 2'b01;
  assign arid              = AXI_ID;
  assign ram_rdata_ready_o = w_beat;
  assign ram_rdata_o       = w_beat ? rdata : '0;
  assign err_o             = r_err;

endmodule

// File: tb/tb_icache_axi_rd.sv
`timescale 1ns/1ps
// Bench for icache_axi_rd: scripted AXI slave, data scoreboard, per-scenario checks.
module tb_icache_axi_rd;

  localparam logic [3:0] ID = 4'h5;

  logic        clk;
  logic        rst;
  logic [31:0] ram_raddr_i;
  logic        ram_raddr_valid_i;
  logic [7:0]  ram_rmask_i;
  logic [3:0]  ram_rsize_i;
  logic [7:0]  ram_rlen_i;
  logic        ram_rdata_ready_o;
  logic [63:0] ram_rdata_o;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic        err_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  icache_axi_rd #(.AXI_ID(ID), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ram_raddr_i(ram_raddr_i), .ram_raddr_valid_i(ram_raddr_valid_i),
    .ram_rmask_i(ram_rmask_i), .ram_rsize_i(ram_rsize_i), .ram_rlen_i(ram_rlen_i),
    .ram_rdata_ready_o(ram_rdata_ready_o), .ram_rdata_o(ram_rdata_o),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every forwarded beat must match the oldest beat the slave sent.
  always @(negedge clk) begin
    n_tests++;
    if (ram_rdata_ready_o) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_beat: got %h, required no beat", ram_rdata_o);
      end else begin
        sb_exp = exp_q.pop_front();
        if (ram_rdata_o !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_data: got %h, required %h", ram_rdata_o, sb_exp);
        end
      end
    end else if (ram_rdata_o !== 64'h0) begin
      n_fail++;
      $display("FAIL sb_idle_data: got %h, required 0", ram_rdata_o);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] a, input logic [7:0] len, input logic [3:0] sz);
    ram_raddr_i       = a;
    ram_rlen_i        = len;
    ram_rsize_i       = sz;
    ram_raddr_valid_i = 1'b1;
  endtask

  task automatic beat(input logic [63:0] d, input logic last, input logic [1:0] resp,
                      input logic [3:0] id);
    rvalid = 1'b1;
    rdata  = d;
    rlast  = last;
    rresp  = resp;
    rid    = id;
    exp_q.push_back(d);
  endtask

  task automatic no_beat;
    rvalid = 1'b0;
    rdata  = '0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    rid    = ID;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #1;
    no_beat();
    ram_raddr_valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if ({arvalid, rready, ram_rdata_ready_o, err_o, araddr, arlen, arsize} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got av=%b rr=%b rdy=%b err=%b addr=%h len=%h size=%h, required all 0",
               arvalid, rready, ram_rdata_ready_o, err_o, araddr, arlen, arsize);
    end
    request(32'hDEAD_BEE0, 8'd3, 4'd8);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_arvalid: got %b, required 0", arvalid);
    end
    ram_raddr_valid_i = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_two_beat;
    int pulses = 0;
    tick();
    request(32'h8000_0010, 8'd1, 4'd8);
    arready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL two_beat_ar_early: got %b, required 0", arvalid);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, 32'h8000_0010, 8'd1, 3'd3, 2'b01, ID}) begin
      n_fail++;
      $display("FAIL two_beat_ar: got v=%b a=%h l=%h s=%h b=%h id=%h, required 1 80000010 01 3 1 %h",
               arvalid, araddr, arlen, arsize, arburst, arid, ID);
    end
    tick();
    beat(64'h1111_1111_1111_1111, 1'b0, 2'b00, ID);
    @(negedge clk);
    pulses += int'(ram_rdata_ready_o);
    n_tests++;
    if ({arvalid, rready} !== 2'b01) begin
      n_fail++;
      $display("FAIL two_beat_r_state: got av/rr=%b%b, required 01", arvalid, rready);
    end
    tick();
    beat(64'h2222_2222_2222_2222, 1'b1, 2'b00, ID);
    @(negedge clk);
    pulses += int'(ram_rdata_ready_o);
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    @(negedge clk);
    pulses += int'(ram_rdata_ready_o);
    n_tests++;
    if ({arvalid, rready} !== 2'b00) begin
      n_fail++;
      $display("FAIL two_beat_done: got av/rr=%b%b, required 00", arvalid, rready);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if (pulses !== 2 || err_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL two_beat_summary: got pulses=%0d err=%b left=%0d, required 2 0 0",
               pulses, err_o, exp_q.size());
    end
  endtask

  task automatic test_ar_backpressure;
    int av = 0;
    int hs = 0;
    tick();
    request(32'h0000_1000, 8'd3, 4'd4);
    arready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) arready = 1'b1;
      @(negedge clk);
      av += int'(arvalid);
      hs += int'(arvalid && arready);
      n_tests++;
      if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h0000_1000, 8'd3, 3'd2}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b a=%h l=%h s=%h, required 1 00001000 03 2",
                 i, arvalid, araddr, arlen, arsize);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      beat(64'hA5A5_0000_0000_0000 | 64'(i), i == 3, 2'b00, ID);
      @(negedge clk);
      av += int'(arvalid);
      hs += int'(arvalid && arready);
    end
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    @(negedge clk);
    av += int'(arvalid);
    tick();
    @(negedge clk);
    av += int'(arvalid);
    n_tests++;
    if (av !== 6 || hs !== 1 || err_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_summary: got av_cycles=%0d handshakes=%0d err=%b left=%0d, required 6 1 0 0",
               av, hs, err_o, exp_q.size());
    end
  endtask

  task automatic test_r_gaps;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tick();
    request(32'h8000_0040, 8'd1, 4'd8);
    arready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (pat[i]) beat(64'hC0DE_0000_0000_0000 | 64'(i), i == 3, 2'b00, ID);
      else        no_beat();
      @(negedge clk);
      n_tests++;
      if (ram_rdata_ready_o !== pat[i]) begin
        n_fail++;
        $display("FAIL gaps_ready_%0d: got %b, required %b", i, ram_rdata_ready_o, pat[i]);
      end
    end
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_tests++;
    if (err_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL gaps_summary: got err=%b left=%0d, required 0 0", err_o, exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int av = 0;
    int hs = 0;
    tick();
    request(32'h8000_2000, 8'd0, 4'd8);
    arready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    av += int'(arvalid);
    hs += int'(arvalid && arready);
    tick();
    beat(64'h8888_8888_8888_8888, 1'b1, 2'b00, ID);
    @(negedge clk);
    av += int'(arvalid);
    tick();
    no_beat();
    @(negedge clk);
    av += int'(arvalid);
    for (int i = 0; i < 2; i++) begin
      tick();
      ram_raddr_valid_i = 1'b0;
      @(negedge clk);
      av += int'(arvalid);
      n_tests++;
      if (arvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_spurious_ar_%0d: got %b, required 0", i, arvalid);
      end
    end
    tick();
    request(32'h8000_3000, 8'd0, 4'd1);
    @(negedge clk);
    av += int'(arvalid);
    tick();
    @(negedge clk);
    av += int'(arvalid);
    hs += int'(arvalid && arready);
    n_tests++;
    if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h8000_3000, 8'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL b2b_second_ar: got v=%b a=%h l=%h s=%h, required 1 80003000 00 0",
               arvalid, araddr, arlen, arsize);
    end
    tick();
    beat(64'h9999_9999_9999_9999, 1'b1, 2'b00, ID);
    @(negedge clk);
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    @(negedge clk);
    av += int'(arvalid);
    tick();
    @(negedge clk);
    av += int'(arvalid);
    n_tests++;
    if (av !== 2 || hs !== 2 || err_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_summary: got av_cycles=%0d handshakes=%0d err=%b left=%0d, required 2 2 0 0",
               av, hs, err_o, exp_q.size());
    end
  endtask

  task automatic test_errors;
    // bad rresp on beat 0: data still forwarded, error from the next cycle, sticky
    tick();
    request(32'h0000_0100, 8'd1, 4'd8);
    arready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    beat(64'h3333_3333_3333_3333, 1'b0, 2'b10, ID);
    @(negedge clk);
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_resp_early: got %b, required 0", err_o);
    end
    tick();
    beat(64'h4444_4444_4444_4444, 1'b1, 2'b00, ID);
    @(negedge clk);
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_resp_set: got %b, required 1", err_o);
    end
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_resp_sticky: got %b, required 1", err_o);
    end
    do_reset();
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_reset: got %b, required 0", err_o);
    end
    // early rlast with rlen 1
    tick();
    request(32'h0000_0200, 8'd1, 4'd8);
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    beat(64'h5555_5555_5555_5555, 1'b1, 2'b00, ID);
    @(negedge clk);
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({err_o, rready, arvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL err_early_last: got err/rr/av=%b%b%b, required 100", err_o, rready, arvalid);
    end
    // unsupported size maps to 3 and flags
    do_reset();
    tick();
    request(32'h0000_0300, 8'd0, 4'd3);
    @(negedge clk);
    tick();
    @(negedge clk);
    n_tests++;
    if ({arvalid, arsize, err_o} !== {1'b1, 3'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL err_bad_size: got av=%b size=%0d err=%b, required 1 3 1", arvalid, arsize, err_o);
    end
    tick();
    beat(64'h6666_6666_6666_6666, 1'b1, 2'b00, ID);
    @(negedge clk);
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    @(negedge clk);
    // wrong rid
    do_reset();
    tick();
    request(32'h0000_0400, 8'd0, 4'd2);
    @(negedge clk);
    tick();
    @(negedge clk);
    n_tests++;
    if ({arsize, err_o} !== {3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL err_size2_map: got size=%0d err=%b, required 1 0", arsize, err_o);
    end
    tick();
    beat(64'h7777_0000_0000_0001, 1'b1, 2'b00, 4'h3);
    @(negedge clk);
    tick();
    no_beat();
    ram_raddr_valid_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (err_o !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL err_bad_rid: got err=%b left=%0d, required 1 0", err_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_r;
    do_reset();
    tick();
    request(32'h8000_1000, 8'd3, 4'd8);
    arready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    beat(64'h7777_7777_7777_7777, 1'b0, 2'b00, ID);
    @(negedge clk);
    tick();
    no_beat();
    @(negedge clk);
    n_tests++;
    if (rready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_r_in_r: got rready=%b, required 1", rready);
    end
    #2;
    rst = 1'b0;
    ram_raddr_valid_i = 1'b0;
    #1;
    n_tests++;
    if ({arvalid, rready, ram_rdata_ready_o, err_o, araddr, arlen, arsize} !== '0) begin
      n_fail++;
      $display("FAIL mid_r_async_reset: got av=%b rr=%b rdy=%b err=%b addr=%h len=%h size=%h, required all 0",
               arvalid, rready, ram_rdata_ready_o, err_o, araddr, arlen, arsize);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      n_tests++;
      if ({arvalid, rready} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_r_no_reissue_%0d: got av/rr=%b%b, required 00", i, arvalid, rready);
      end
    end
  endtask

  initial begin
    rst               = 1'b0;
    ram_raddr_i       = '0;
    ram_raddr_valid_i = 1'b0;
    ram_rmask_i       = 8'hFF;
    ram_rsize_i       = 4'd8;
    ram_rlen_i        = '0;
    arready           = 1'b0;
    no_beat();
    test_reset();
    test_two_beat();
    test_ar_backpressure();
    test_r_gaps();
    test_back_to_back();
    test_errors();
    test_reset_mid_r();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd.md
ICACHE_AXI_RD -- requirements
Module: icache_axi_rd

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0: constant driven on arid.
REQ-002 SHALL have parameter DATA_W, default 64: data width of the cache-side and AXI R channels.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ram_raddr_i  input  32  line-aligned burst start address from icache.
REQ-006 ram_raddr_valid_i  input  1  request valid; held high by icache until the last beat.
REQ-007 ram_rmask_i  input  8  read mask; accepted, not forwarded (AXI reads are full-width).
REQ-008 ram_rsize_i  input  4  bytes per beat, one-hot: 1/2/4/8.
REQ-009 ram_rlen_i  input  8  beats minus one.
REQ-010 ram_rdata_ready_o  output  1  per-beat strobe; data valid this cycle.
REQ-011 ram_rdata_o  output  DATA_W  beat data.
REQ-012 arvalid/arready/araddr[31:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]/arid[3:0]  out/in/out/out/out/out/out  AXI4 AR channel.
REQ-013 rvalid/rready/rdata[DATA_W-1:0]/rresp[1:0]/rlast/rid[3:0]  in/out/in/in/in/in  AXI4 R channel.
REQ-014 err_o  output  1  sticky error flag.

Function
REQ-015 SHALL implement FSM states IDLE, AR, R, DONE.
REQ-016 IDLE: when ram_raddr_valid_i=1, SHALL latch address, rlen and rsize and go to AR at the next edge; otherwise remain in IDLE.
REQ-017 AR: SHALL drive arvalid=1 with the latched fields; AR fields SHALL stay stable while arvalid=1 and arready=0.
REQ-018 AR: on arvalid&arready, SHALL clear arvalid and go to R at the same edge.
REQ-019 araddr = latched address, unmodified; arlen = latched rlen; arburst = 2'b01 (INCR); arid = AXI_ID.
REQ-020 arsize mapping: rsize 1->0, 2->1, 4->2, 8->3; any other value -> 3 and set err_o.
REQ-021 R: rready SHALL be 1; rready SHALL be 0 in all other states.
REQ-022 ram_rdata_ready_o SHALL equal (state==R)&rvalid, combinationally; ram_rdata_o SHALL equal rdata in that cycle and 0 otherwise.
REQ-023 An 8-bit beat counter SHALL clear on entry to AR and increment on each rvalid&rready.
REQ-024 On rvalid&rready&rlast, SHALL go to DONE.
REQ-025 If rlast arrives with counter != latched rlen, or counter == rlen without rlast, SHALL set err_o; burst termination SHALL still follow rlast only.
REQ-026 rresp != 2'b00 or rid != AXI_ID on any beat SHALL set err_o; data SHALL still be forwarded.
REQ-027 DONE: SHALL last exactly one cycle, then return to IDLE, so a valid still high for one cycle after the final beat does not restart a burst.
REQ-028 Latency: request seen in IDLE at cycle N -> arvalid=1 at N+1; first beat forwarded in the same cycle rvalid is seen in R.
REQ-029 A change of ram_raddr_valid_i outside IDLE SHALL be ignored; a transaction always completes once AR has been issued.
REQ-030 err_o SHALL remain set until reset.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE and drive arvalid, rready, ram_rdata_ready_o, ram_rdata_o, err_o, araddr, arlen and arsize to 0, regardless of clk.
REQ-032 Reset asserted mid-AR or mid-R SHALL abandon the transaction; after rst=1, the block SHALL restart in IDLE without AR reissue until a new request is seen.

Verification
REQ-033 Two-beat line: addr 0x8000_0010, rlen 1, rsize 8, arready=1 -> araddr 0x8000_0010, arlen 1, arsize 3, arburst 1; beats 0x1111.., 0x2222.. forwarded with two ready pulses; IDLE two cycles after rlast.
REQ-034 AR backpressure: arready low for 5 cycles -> arvalid held 5+1 cycles with stable fields; exactly one AR handshake.
REQ-035 R gaps: rvalid toggles 1,0,0,1(rlast) -> ram_rdata_ready_o pulses only in the two rvalid cycles; err_o=0.
REQ-036 Errors: rresp=2'b10 on beat 0 -> err_o=1 from the next cycle and sticky; separately, rlast on beat 0 with rlen 1 -> err_o=1, FSM to DONE.
REQ-037 Reset mid-R after beat 0 -> rready and arvalid 0 asynchronously; after release with valid low, no AR issued.
REQ-038 Back-to-back: valid held one cycle past the last beat, then a new request 2 cycles later -> exactly one new AR, no spurious AR.
